// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings and decode helpers for the MD issue controller.
package md_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  // Decode bounds: ops 1..4 start the unit, ops 1..8 talk to it at all.
  localparam logic [3:0] MD_START_LO = 4'd1;
  localparam logic [3:0] MD_START_HI = 4'd4;
  localparam logic [3:0] MD_CLASS_HI = 4'd8;

  // HI/LO read select presented alongside the E-stage op.
  localparam logic [1:0] MF_NONE = 2'd0;
  localparam logic [1:0] MF_HI   = 2'd1;
  localparam logic [1:0] MF_LO   = 2'd2;

  function automatic logic is_start(input logic [3:0] op);
    return (op >= MD_START_LO) && (op <= MD_START_HI);
  endfunction

  function automatic logic is_md(input logic [3:0] op);
    return (op >= MD_START_LO) && (op <= MD_CLASS_HI);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Reserved codes 9..15 behave exactly like "no op".
  function automatic logic [3:0] norm_op(input logic [3:0] op);
    return (op > MD_CLASS_HI) ? MD_NONE : op;
  endfunction

  function automatic logic [1:0] mf_sel_of(input logic [3:0] op);
    case (op)
      MD_MFHI: return MF_HI;
      MD_MFLO: return MF_LO;
      default: return MF_NONE;
    endcase
  endfunction

endpackage

// File: rtl/md_issue_ctrl_occupancy_fsm.sv
// Local mirror of MDU occupancy: IDLE/MUL/DIV with a cycle counter.
import md_issue_ctrl_pkg::*;

module md_occupancy_fsm #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] e_md_op,
  output logic       busy_mirror
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset abandons any mirrored operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a start op in E launches, the counter times the busy window.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_mirror = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (is_mul(e_md_op)) begin
          state_d = MUL;
          cnt_d   = CNT_ONE;
        end else if (is_div(e_md_op)) begin
          state_d = DIV;
          cnt_d   = CNT_ONE;
        end
      end
      MUL: begin
        if (cnt_q == MULT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DIV: begin
        if (cnt_q == DIV_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// D->E register for MD ops, MD stall generation and MDU consistency check.
import md_issue_ctrl_pkg::*;

module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  d_md_op,
  input  logic [31:0] d_rs,
  input  logic [31:0] d_rt,
  input  logic        stall_ext,
  input  logic        md_busy,
  output logic        stall_md,
  output logic [3:0]  e_md_op,
  output logic [31:0] e_A,
  output logic [31:0] e_B,
  output logic [1:0]  e_mf_sel,
  output logic        busy_mirror,
  output logic        desync
);

  logic armed;

  md_occupancy_fsm #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_occ (
    .clk         (clk),
    .reset       (reset),
    .e_md_op     (e_md_op),
    .busy_mirror (busy_mirror)
  );

  // Any MD op waits while a start sits in E or the unit is still working.
  always_comb begin
    stall_md = is_md(d_md_op) && (is_start(e_md_op) || busy_mirror);
  end

  // E register: bubble on any stall, operands hold so they never toggle needlessly.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_md_op  <= MD_NONE;
      e_A      <= '0;
      e_B      <= '0;
      e_mf_sel <= MF_NONE;
    end else if (stall_md || stall_ext) begin
      e_md_op  <= MD_NONE;
      e_mf_sel <= MF_NONE;
    end else begin
      e_md_op  <= norm_op(d_md_op);
      e_A      <= d_rs;
      e_B      <= d_rt;
      e_mf_sel <= mf_sel_of(norm_op(d_md_op));
    end
  end

  // Sticky mismatch flag; the first edge after reset is skipped while the MDU settles.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed  <= 1'b0;
      desync <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (armed && (md_busy != busy_mirror)) desync <= 1'b1;
    end
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Requester-side companion of the pipeline multiply/divide unit (MDU).
- Sits between D and E stages and registers the D-stage MD operation and operands into E.
- Issues a one-cycle operation code to the MDU and mirrors the MDU occupancy with its own state machine.
- Generates the D-stage stall for every MD-class instruction (mult/multu/div/divu/mthi/mtlo/mfhi/mflo) while the unit is starting or busy.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issue.
- DIV_CYCLES, 10, busy cycles after a div/divu issue.
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- d_md_op  input  4  D-stage MD op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo.
- d_rs  input  32  D-stage rs operand (forwarded).
- d_rt  input  32  D-stage rt operand (forwarded).
- stall_ext  input  1  stall from other hazard sources (load-use etc.).
- md_busy  input  1  busy flag returned by the MDU, used for consistency check only.
- stall_md  output  1  MD-caused D-stage stall, combinational.
- e_md_op  output  4  E-stage op presented to the MDU; ops 1..6 act as issue.
- e_A  output  32  E-stage operand A to the MDU.
- e_B  output  32  E-stage operand B to the MDU.
- e_mf_sel  output  2  E-stage HI/LO read select: 0 none, 1 HI (mfhi), 2 LO (mflo).
- busy_mirror  output  1  local occupancy, high while in MUL or DIV state.
- desync  output  1  sticky flag: md_busy != busy_mirror was seen.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All state changes occur on the rising edge of clk.
- Reset values:
  - e_md_op=0, e_A=0, e_B=0, e_mf_sel=0.
  - State IDLE, cnt=0, busy_mirror=0, desync=0.
  - Reset takes priority over every other event. Reset mid-operation abandons the mirrored operation and returns to IDLE next edge.
- Op classes:
  - start-class = ops 1..4.
  - md-class = ops 1..8.
  - Codes 9..15 are treated as 0.
- State machine:
  - States: IDLE, MUL, DIV.
  - IDLE -> MUL when e_md_op is 1 or 2. Set cnt=1.
  - IDLE -> DIV when e_md_op is 3 or 4. Set cnt=1.
  - In MUL: cnt increments each edge. Return to IDLE on the edge where cnt==MULT_CYCLES, clearing cnt.
  - In DIV: same, with DIV_CYCLES.
  - mthi/mtlo/mfhi/mflo in E never change state.
  - busy_mirror = (state != IDLE). A mult issued in cycle t gives busy_mirror high in cycles t+1..t+MULT_CYCLES.
- Stall: stall_md = d_md_op is md-class AND (e_md_op is start-class OR busy_mirror).
- E register update each edge, with no reset:
  - If stall_md or stall_ext: insert a bubble (e_md_op=0, e_mf_sel=0). e_A/e_B are don't-care but hold their value.
  - Else: e_md_op<=d_md_op, e_A<=d_rs, e_B<=d_rt, e_mf_sel<=(7->1, 8->2, else 0).
- Timing guarantees:
  - A start-class op reaches e_md_op only when the state is IDLE and no start is in E, so back-to-back starts are impossible.
  - The first dependent MD op enters E in cycle t+MULT_CYCLES+1 (div: t+DIV_CYCLES+1).
  - mfhi/mflo in E therefore always reads the completed result.
- Simultaneous events:
  - stall_ext high with an MD op in E: the issue still happens. Stall affects only D->E transfer.
  - Non-MD ops in D never see stall_md.
- Desync check: from the second cycle after reset, desync is set on any edge where md_busy != busy_mirror. It is cleared only by reset.
- Width rules: operands pass through unmodified; no arithmetic is performed here.

Decomposition:
- Shared package holds:
  - MD op encodings (MD_NONE..MD_MFLO).
  - Helper constants for start-class and md-class decoding.
  - State encodings IDLE=2'd0, MUL=2'd1, DIV=2'd2.
- One natural sub-module: md_occupancy_fsm, containing the state register, cnt and busy_mirror.
- The top level holds the E register, the stall logic and the desync flag.

Test Plan:
- Mult then dependent mflo: D=mult (rs=3, rt=7) at t0, D=mflo at t1 -> e_md_op=1 at t1; stall_md high t1..t6; mflo enters E at t7 with e_mf_sel=2; busy_mirror high t2..t6.
- Back-to-back div/divu: div(100,7) then divu in D -> second op stalls exactly 11 cycles (start plus DIV_CYCLES=10); never two start-class ops in consecutive E cycles.
- Independent work during busy: mult issued, then 5 ALU ops in D -> stall_md=0 throughout; E receives e_md_op=0 each cycle.
- mthi while busy: div in flight, D=mthi (rs=0xDEADBEEF) -> stalled until IDLE, then e_md_op=5 and e_A=0xDEADBEEF; state stays IDLE afterwards.
- stall_ext interaction: stall_ext=1 with mult in D and unit IDLE -> bubble in E, no issue; stall_ext=0 next cycle -> e_md_op=1.
- Reset mid-divide: reset at cnt=4 in DIV -> next edge state IDLE, busy_mirror=0, e_md_op=0, desync=0; a waiting mult issues on the first non-reset cycle.
